idwt_frame_sequencer: RTL and testbench

//  Sequences one frame of inverse-DWT coefficient pairs into the inverse DWT image writer.

---
 rtl/idwt_frame_sequencer.sv | 107 ++++++++++
 tb/tb_idwt_frame_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/idwt_frame_sequencer.sv
// idwt_frame_sequencer: streams one frame of L/H coefficient beats into the inverse-DWT writer, column-major
module idwt_frame_sequencer #(
  parameter int WIDTH          = 20,
  parameter int HEIGHT         = 30,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int DONE_TIMEOUT   = 1024
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       start,
  input  logic       abort,
  input  logic       src_valid,
  output logic       src_ready,
  output logic       wr_hsync,
  output logic [7:0] col_idx,
  output logic [8:0] row_idx,
  input  logic       wr_done,
  output logic       busy,
  output logic       frame_done,
  output logic       err
);
  localparam int SG_MAX = START_UP_DELAY > HSYNC_DELAY ? START_UP_DELAY : HSYNC_DELAY;
  localparam int MAX_D  = SG_MAX > DONE_TIMEOUT ? SG_MAX : DONE_TIMEOUT;
  localparam int CW     = $clog2(MAX_D + 1);
  localparam logic [CW-1:0] SU_END   = CW'(START_UP_DELAY - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(HSYNC_DELAY - 1);
  localparam logic [CW-1:0] TO_END   = CW'(DONE_TIMEOUT - 1);
  localparam logic [7:0]    LAST_COL = 8'(WIDTH / 2 - 1);
  localparam logic [8:0]    LAST_ROW = 9'(HEIGHT - 2);
  localparam logic [2:0] IDLE = 3'd0, STARTUP = 3'd1, XFER = 3'd2, GAP = 3'd3, WAIT_DONE = 3'd4, DONE = 3'd5;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    col_q, col_d;
  logic [8:0]    row_q, row_d;
  logic          err_q, err_d;
  logic          beat, last_row, last_col;
  assign src_ready  = state_q == XFER;
  assign beat       = src_valid & src_ready;
  assign wr_hsync   = beat;
  assign col_idx    = col_q;
  assign row_idx    = row_q;
  assign busy       = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign err        = err_q;
  assign last_row   = row_q == LAST_ROW;
  assign last_col   = col_q == LAST_COL;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = START_UP_DELAY == 0 ? XFER : STARTUP;
        cnt_d   = '0;
        col_d   = '0;
        row_d   = '0;
        err_d   = 1'b0;
      end
      STARTUP: begin
        cnt_d   = cnt_q == SU_END ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == SU_END ? XFER : STARTUP;
      end
      XFER: if (beat) begin
        row_d   = last_row ? '0 : row_q + 9'd2;
        col_d   = last_row ? (last_col ? '0 : col_q + 1'b1) : col_q;
        state_d = !last_row ? XFER : last_col ? WAIT_DONE : HSYNC_DELAY == 0 ? XFER : GAP;
      end
      GAP: begin
        cnt_d   = cnt_q == GAP_END ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == GAP_END ? XFER : GAP;
      end
      WAIT_DONE: begin
        // wr_done wins over a timeout landing on the same cycle
        cnt_d   = (wr_done || cnt_q == TO_END) ? '0 : cnt_q + 1'b1;
        state_d = wr_done ? DONE : cnt_q == TO_END ? IDLE : WAIT_DONE;
        err_d   = err_q | (!wr_done && cnt_q == TO_END);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      col_d   = '0;
      row_d   = '0;
      err_d   = err_q;
    end
  end
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_idwt_frame_sequencer.sv
// tb_idwt_frame_sequencer: scoreboard bench for the frame sequencer with a small 4x4 frame
module tb_idwt_frame_sequencer;
  logic HCLK = 1'b0, HRESETn = 1'b0, start = 1'b0, abort = 1'b0, src_valid = 1'b0, wr_done = 1'b0;
  logic src_ready, wr_hsync, busy, frame_done, err;
  logic [7:0] col_idx;
  logic [8:0] row_idx;
  logic src_ready0, hs0, busy0, fd0, err0;
  logic [7:0] col0;
  logic [8:0] row0;
  int n_checks = 0, n_errors = 0;
  int hs_cnt = 0, fd_cnt = 0, hs_base = 0, fd_base = 0, k = 0;
  logic [16:0] sb[$];
  logic [5:0] pat;
  logic [7:0] pat8;
  idwt_frame_sequencer #(.WIDTH(4), .HEIGHT(4), .START_UP_DELAY(3), .HSYNC_DELAY(2), .DONE_TIMEOUT(8)) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort), .src_valid(src_valid),
    .src_ready(src_ready), .wr_hsync(wr_hsync), .col_idx(col_idx), .row_idx(row_idx),
    .wr_done(wr_done), .busy(busy), .frame_done(frame_done), .err(err));
  idwt_frame_sequencer #(.WIDTH(4), .HEIGHT(4), .START_UP_DELAY(3), .HSYNC_DELAY(0), .DONE_TIMEOUT(8)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort), .src_valid(src_valid),
    .src_ready(src_ready0), .wr_hsync(hs0), .col_idx(col0), .row_idx(row0),
    .wr_done(wr_done), .busy(busy0), .frame_done(fd0), .err(err0));
  always #5 HCLK = ~HCLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge HCLK) begin
    if (wr_hsync) begin
      hs_cnt <= hs_cnt + 1;
      if (sb.size() == 0) check("extra_beat", 32'(wr_hsync), 32'd0);
      else check("beat_idx", {15'd0, col_idx, row_idx}, {15'd0, sb.pop_front()});
    end else if (src_ready && sb.size() > 0) check("stall_idx", {15'd0, col_idx, row_idx}, {15'd0, sb[0]});
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end
  task automatic step;
    @(posedge HCLK);
    #1;
  endtask
  task automatic start_frame;
    sb.delete();
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 4; r += 2) sb.push_back({c[7:0], r[8:0]});
    hs_base = hs_cnt;
    start = 1'b1;
    step;
    start = 1'b0;
  endtask
  task automatic wait_beats(input int n);
    int j = 0;
    while (hs_cnt - hs_base < n && j < 200) begin
      step;
      j++;
    end
    check("beats_reached", 32'(hs_cnt - hs_base >= n), 32'd1);
  endtask
  task automatic wait_fd(output int kk);
    kk = 0;
    while (!frame_done && kk < 100) begin
      step;
      kk++;
    end
    check("fd_seen", 32'(frame_done), 32'd1);
  endtask
  initial begin
    step;
    step;
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(src_ready), 0);
    check("rst_hsync", 32'(wr_hsync), 0);
    check("rst_fd", 32'(frame_done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_idx", {15'd0, col_idx, row_idx}, 0);
    HRESETn = 1'b1;
    src_valid = 1'b1;
    step;
    start_frame;
    check("busy_after_start", 32'(busy), 1);
    check("ready_startup", 32'(src_ready), 0);
    k = 0;
    while (!wr_hsync && k < 50) begin step; k++; end
    check("startup_lat", k, 3);
    for (int i = 0; i < 6; i++) begin pat[i] = wr_hsync; step; end
    check("hs_pattern", 32'(pat), 32'b110011);
    check("beats_f1", hs_cnt - hs_base, 4);
    check("sb_empty_f1", sb.size(), 0);
    fd_base = fd_cnt;
    step;
    wr_done = 1'b1;
    wait_fd(k);
    check("done_lat", k, 1);
    wr_done = 1'b0;
    step;
    check("fd_pulse", 32'(frame_done), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_err", 32'(err), 0);
    check("fd_count", fd_cnt - fd_base, 1);
    start_frame;
    for (int i = 0; i < 60 && hs_cnt - hs_base < 4; i++) begin
      src_valid = i[0];
      start = i == 5;
      step;
      start = 1'b0;
    end
    src_valid = 1'b1;
    check("beats_f3", hs_cnt - hs_base, 4);
    check("sb_empty_f3", sb.size(), 0);
    check("busy_f3", 32'(busy), 1);
    wr_done = 1'b1;
    wait_fd(k);
    wr_done = 1'b0;
    step;
    step;
    check("beats_after_f3", hs_cnt - hs_base, 4);
    check("idle_f3", 32'(busy), 0);
    fd_base = fd_cnt;
    start_frame;
    wait_beats(4);
    k = 0;
    while (!err && k < 50) begin step; k++; end
    check("timeout_lat", k, 8);
    check("to_busy", 32'(busy), 0);
    check("to_fd", fd_cnt - fd_base, 0);
    repeat (3) step;
    check("err_sticky", 32'(err), 1);
    start_frame;
    check("err_clear", 32'(err), 0);
    wait_beats(2);
    check("gap_ready", 32'(src_ready), 0);
    check("gap_busy", 32'(busy), 1);
    abort = 1'b1;
    step;
    abort = 1'b0;
    check("abort_idle", 32'(busy), 0);
    check("abort_fd", fd_cnt - fd_base, 0);
    start_frame;
    k = 0;
    while (!wr_hsync && k < 50) begin step; k++; end
    check("restart_lat", k, 3);
    wr_done = 1'b1;
    wait_fd(k);
    wr_done = 1'b0;
    step;
    check("beats_f5", hs_cnt - hs_base, 4);
    start_frame;
    wait_beats(1);
    HRESETn = 1'b0;
    start = 1'b1;
    step;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(src_ready), 0);
    check("mid_rst_hsync", 32'(wr_hsync), 0);
    check("mid_rst_idx", {15'd0, col_idx, row_idx}, 0);
    check("mid_rst_err", 32'(err), 0);
    step;
    check("rst_start_ign", 32'(busy), 0);
    HRESETn = 1'b1;
    start = 1'b0;
    step;
    check("post_rst_idle", 32'(busy), 0);
    start_frame;
    k = 0;
    while (!hs0 && k < 50) begin step; k++; end
    check("hd0_lat", k, 3);
    for (int i = 0; i < 8; i++) begin pat8[i] = hs0; step; end
    check("hd0_pattern", 32'(pat8), 32'b00001111);
    wr_done = 1'b1;
    wait_fd(k);
    wr_done = 1'b0;
    step;
    check("beats_f6", hs_cnt - hs_base, 4);
    check("sb_empty_f6", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
